// File: rtl/read_axi_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : read_axi_buffer_pkg
// Purpose  : Shared cache-subsystem constants: AXI burst/size codes, read
//            buffer state encoding and default line size.
// Revision : 1.0 - initial release
// ============================================================================
package read_axi_buffer_pkg;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    localparam logic [2:0] c_AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] c_AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] c_AXI_SIZE_4B = 3'd2;
    localparam logic [2:0] c_AXI_SIZE_8B = 3'd3;

    // Shared with the write buffer so both sides agree on the line geometry.
    localparam int c_LINE_SIZE_DEFAULT = 16;

    typedef enum logic [1:0] {
        RB_IDLE      = 2'd0,
        RB_WAIT_ADDR = 2'd1,
        RB_WAIT_DATA = 2'd2,
        RB_DONE      = 2'd3
    } rb_state_t;

endpackage
`default_nettype wire

// File: rtl/read_axi_buffer.sv
`default_nettype none
// ============================================================================
// Module   : read_axi_buffer
// Purpose  : AXI4 read initiator for cache refills (line burst or single
//            uncached beat). Optional macro: CRITICAL_WORD_FIRST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module read_axi_buffer
    import read_axi_buffer_pkg::*;
#(
    parameter int LINE_SIZE = c_LINE_SIZE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   uncached,
    input  logic [31:0]            addr,
    input  logic [2:0]             size,
    output logic                   empty,
    output logic                   done,
    output logic [LINE_SIZE*8-1:0] line_data,
    output logic [31:0]            word_data,
    output logic [31:0]            axi_araddr,
    output logic [7:0]             axi_arlen,
    output logic [2:0]             axi_arsize,
    output logic [1:0]             axi_arburst,
    output logic                   axi_arvalid,
    input  logic                   axi_arready,
    input  logic [31:0]            axi_rdata,
    input  logic                   axi_rlast,
    input  logic                   axi_rvalid,
    output logic                   axi_rready
);

    localparam int c_N     = LINE_SIZE / 4;
    localparam int c_OFF   = $clog2(LINE_SIZE);
    localparam int c_IDX_W = $clog2(c_N);

    rb_state_t r_state;
    rb_state_t w_next;

    logic                      r_uncached;
    logic [c_IDX_W-1:0]        r_start;
    logic [3:0]                r_count;
    logic [c_N-1:0][31:0]      r_line;
    logic [31:0]               r_word;
    logic [31:0]               r_araddr;
    logic [7:0]                r_arlen;
    logic [2:0]                r_arsize;
    logic [1:0]                r_arburst;
    logic                      r_arvalid;

    logic [c_IDX_W-1:0]        w_idx;
    logic [3:0]                w_count_next;

    always_ff @(posedge clk) begin
        if (rst) r_state <= RB_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RB_IDLE:      if (en)                       w_next = RB_WAIT_ADDR;
            RB_WAIT_ADDR: if (axi_arready)              w_next = RB_WAIT_DATA;
            RB_WAIT_DATA: if (axi_rvalid && axi_rlast)  w_next = RB_DONE;
            RB_DONE:                                    w_next = RB_IDLE;
            default:                                    w_next = RB_IDLE;
        endcase
    end

    // Beat slot in the line; with critical-word-first the burst starts at the
    // requested word and wraps around the line.
`ifdef CRITICAL_WORD_FIRST_EN
    assign w_idx = r_uncached ? r_count[c_IDX_W-1:0]
                              : r_start + r_count[c_IDX_W-1:0];
`else
    assign w_idx = r_count[c_IDX_W-1:0];
`endif

    assign w_count_next = (r_count == 4'(c_N - 1)) ? 4'd0 : r_count + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_uncached <= 1'b0;
            r_start    <= '0;
            r_count    <= 4'd0;
            r_line     <= '0;
            r_word     <= 32'd0;
            r_araddr   <= 32'd0;
            r_arlen    <= 8'd0;
            r_arsize   <= 3'd0;
            r_arburst  <= c_BURST_INCR;
            r_arvalid  <= 1'b0;
        end else begin
            if (r_state == RB_IDLE && en) begin
                r_uncached <= uncached;
                r_start    <= addr[c_OFF-1:2];
                r_arvalid  <= 1'b1;
                if (uncached) begin
                    r_araddr  <= addr;
                    r_arlen   <= 8'd0;
                    r_arsize  <= size;
                    r_arburst <= c_BURST_INCR;
                end else begin
                    r_arlen   <= 8'(c_N - 1);
                    r_arsize  <= c_AXI_SIZE_4B;
`ifdef CRITICAL_WORD_FIRST_EN
                    r_araddr  <= {addr[31:2], 2'b00};
                    r_arburst <= c_BURST_WRAP;
`else
                    r_araddr  <= addr & ~32'(LINE_SIZE - 1);
                    r_arburst <= c_BURST_INCR;
`endif
                end
            end

            if (r_state == RB_WAIT_ADDR && axi_arready) begin
                r_arvalid <= 1'b0;
                r_count   <= 4'd0;
            end

            if (r_state == RB_WAIT_DATA && axi_rvalid) begin
                r_line[w_idx] <= axi_rdata;
                r_count       <= w_count_next;
                if (r_uncached)
                    r_word <= axi_rdata;
`ifdef CRITICAL_WORD_FIRST_EN
                else if (r_count == 4'd0)
                    r_word <= axi_rdata;
`endif
            end

`ifndef CRITICAL_WORD_FIRST_EN
            // Latch the selected word so it holds after the done cycle.
            if (r_state == RB_DONE && !r_uncached)
                r_word <= r_line[r_start];
`endif
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    assign word_data = r_word;
`else
    assign word_data = (r_state == RB_DONE && !r_uncached) ? r_line[r_start] : r_word;
`endif

    assign empty       = (r_state == RB_IDLE);
    assign done        = (r_state == RB_DONE);
    assign axi_rready  = (r_state == RB_WAIT_DATA);
    assign line_data   = r_line;
    assign axi_araddr  = r_araddr;
    assign axi_arlen   = r_arlen;
    assign axi_arsize  = r_arsize;
    assign axi_arburst = r_arburst;
    assign axi_arvalid = r_arvalid;

endmodule
`default_nettype wire

// File: tb/tb_read_axi_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_axi_buffer
// Purpose  : Self-checking bench for read_axi_buffer (LINE_SIZE = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_axi_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         uncached;
    logic [31:0]  addr;
    logic [2:0]   size;
    logic         empty;
    logic         done;
    logic [127:0] line_data;
    logic [31:0]  word_data;
    logic [31:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic [2:0]   axi_arsize;
    logic [1:0]   axi_arburst;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [31:0]  axi_rdata;
    logic         axi_rlast;
    logic         axi_rvalid;
    logic         axi_rready;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [1:0] c_CBURST = 2'b10;
`else
    localparam logic [1:0] c_CBURST = 2'b01;
`endif

    read_axi_buffer #(.LINE_SIZE(16)) dut (
        .clk(clk), .rst(rst), .en(en), .uncached(uncached), .addr(addr),
        .size(size), .empty(empty), .done(done), .line_data(line_data),
        .word_data(word_data), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    typedef struct {
        logic             unc;
        logic [31:0]      addr;
        logic [2:0]       size;
        int               nb;
        logic [3:0][31:0] beats;
        logic [31:0]      e_araddr;
        logic [7:0]       e_arlen;
        logic [2:0]       e_arsize;
        logic [1:0]       e_arburst;
        logic [127:0]     e_line;
        logic [31:0]      e_word;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input logic unc, input logic [31:0] a,
                                input logic [2:0] sz, input int nb,
                                input logic [127:0] beats,
                                input logic [31:0] ea, input logic [7:0] el,
                                input logic [2:0] es, input logic [1:0] eb,
                                input logic [127:0] eline, input logic [31:0] ew);
        vec_t v;
        v.unc = unc; v.addr = a; v.size = sz; v.nb = nb; v.beats = beats;
        v.e_araddr = ea; v.e_arlen = el; v.e_arsize = es; v.e_arburst = eb;
        v.e_line = eline; v.e_word = ew;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int ar_wait, input int gap, input string tag);
        int d0;
        chk({tag, " empty_before"}, 128'(empty), 128'(1'b1));
        en = 1'b1; uncached = v.unc; addr = v.addr; size = v.size;
        tick();
        en = 1'b0;
        chk({tag, " arvalid"}, 128'(axi_arvalid), 128'(1'b1));
        chk({tag, " araddr"},  128'(axi_araddr),  128'(v.e_araddr));
        chk({tag, " arlen"},   128'(axi_arlen),   128'(v.e_arlen));
        chk({tag, " arsize"},  128'(axi_arsize),  128'(v.e_arsize));
        chk({tag, " arburst"}, 128'(axi_arburst), 128'(v.e_arburst));
        for (int i = 0; i < ar_wait; i++) begin
            axi_rvalid = 1'b1; axi_rdata = 32'hBAD0_0000 + 32'(i); axi_rlast = 1'b1;
            chk({tag, " rready_in_wait_addr"}, 128'(axi_rready), 128'(1'b0));
            tick();
            chk({tag, " araddr_stable"},  128'(axi_araddr),  128'(v.e_araddr));
            chk({tag, " arvalid_stable"}, 128'(axi_arvalid), 128'(1'b1));
        end
        axi_rvalid = 1'b0; axi_rlast = 1'b0;
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        chk({tag, " arvalid_cleared"}, 128'(axi_arvalid), 128'(1'b0));
        chk({tag, " rready"},          128'(axi_rready),  128'(1'b1));
        d0 = done_cnt;
        for (int k = 0; k < v.nb; k++) begin
            repeat (gap) tick();
            axi_rvalid = 1'b1; axi_rdata = v.beats[k]; axi_rlast = (k == v.nb - 1);
            tick();
            axi_rvalid = 1'b0; axi_rlast = 1'b0;
        end
        chk({tag, " done"},      128'(done),      128'(1'b1));
        chk({tag, " line_data"}, line_data,       v.e_line);
        chk({tag, " word_data"}, 128'(word_data), 128'(v.e_word));
        tick();
        chk({tag, " done_low"},    128'(done),          128'(1'b0));
        chk({tag, " empty_after"}, 128'(empty),         128'(1'b1));
        chk({tag, " done_once"},   128'(done_cnt - d0), 128'(1));
        chk({tag, " word_hold"},   128'(word_data),     128'(v.e_word));
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        axi_rvalid = 1'b1; axi_rdata = d; axi_rlast = last;
        tick();
        axi_rvalid = 1'b0; axi_rlast = 1'b0;
    endtask

    initial begin
        int d0;
        vec_t va;
        rst = 1'b1; en = 1'b0; uncached = 1'b0; addr = 32'd0; size = 3'd0;
        axi_arready = 1'b0; axi_rdata = 32'd0; axi_rlast = 1'b0; axi_rvalid = 1'b0;

`ifdef CRITICAL_WORD_FIRST_EN
        vecs[0] = mk(0, 32'h1000_0028, 3'd0, 4, {32'hB3, 32'hB2, 32'hB1, 32'hB0},
                     32'h1000_0028, 8'd3, 3'd2, 2'b10,
                     {32'hB1, 32'hB0, 32'hB3, 32'hB2}, 32'hB0);
        vecs[1] = mk(1, 32'h1FC0_0003, 3'd0, 1, 128'h55,
                     32'h1FC0_0003, 8'd0, 3'd0, 2'b01,
                     {32'hB1, 32'hB0, 32'hB3, 32'h55}, 32'h55);
        vecs[2] = mk(0, 32'h2000_003C, 3'd0, 4, {32'h44, 32'h33, 32'h22, 32'h11},
                     32'h2000_003C, 8'd3, 3'd2, 2'b10,
                     {32'h11, 32'h44, 32'h33, 32'h22}, 32'h11);
`else
        vecs[0] = mk(0, 32'h1000_0024, 3'd0, 4, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
                     32'h1000_0020, 8'd3, 3'd2, 2'b01,
                     {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 32'hA1);
        vecs[1] = mk(1, 32'h1FC0_0003, 3'd0, 1, 128'h55,
                     32'h1FC0_0003, 8'd0, 3'd0, 2'b01,
                     {32'hA3, 32'hA2, 32'hA1, 32'h55}, 32'h55);
        vecs[2] = mk(0, 32'h2000_003C, 3'd0, 4, {32'h44, 32'h33, 32'h22, 32'h11},
                     32'h2000_0030, 8'd3, 3'd2, 2'b01,
                     {32'h44, 32'h33, 32'h22, 32'h11}, 32'h44);
`endif
        vecs[3] = mk(0, 32'h0000_0000, 3'd0, 4,
                     {32'h89AB_CDEF, 32'h0123_4567, 32'hCAFE_F00D, 32'hDEAD_BEEF},
                     32'h0000_0000, 8'd3, 3'd2, c_CBURST,
                     {32'h89AB_CDEF, 32'h0123_4567, 32'hCAFE_F00D, 32'hDEAD_BEEF},
                     32'hDEAD_BEEF);
        vecs[4] = mk(1, 32'h8000_0006, 3'd1, 1, 128'h1234_5678,
                     32'h8000_0006, 8'd0, 3'd1, 2'b01,
                     {32'h89AB_CDEF, 32'h0123_4567, 32'hCAFE_F00D, 32'h1234_5678},
                     32'h1234_5678);

        repeat (3) tick();
        chk("rst arvalid",  128'(axi_arvalid), 128'(1'b0));
        chk("rst araddr",   128'(axi_araddr),  128'(32'd0));
        chk("rst arlen",    128'(axi_arlen),   128'(8'd0));
        chk("rst arsize",   128'(axi_arsize),  128'(3'd0));
        chk("rst arburst",  128'(axi_arburst), 128'(2'b01));
        chk("rst rready",   128'(axi_rready),  128'(1'b0));
        chk("rst done",     128'(done),        128'(1'b0));
        chk("rst line",     line_data,         128'd0);
        chk("rst word",     128'(word_data),   128'(32'd0));
        chk("rst empty",    128'(empty),       128'(1'b1));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_txn(vecs[i], 0, 0, $sformatf("vec%0d", i));

        // Slow slave: delayed arready, junk R traffic during address phase, gaps.
        va = mk(0, 32'h3000_0040, 3'd0, 4, {32'hC3, 32'hC2, 32'hC1, 32'hC0},
                32'h3000_0040, 8'd3, 3'd2, c_CBURST,
                {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 32'hC0);
        run_txn(va, 5, 2, "slow");

        // en held high across a whole transfer.
        en = 1'b1; uncached = 1'b0; addr = 32'h4000_0000;
        tick();
        addr = 32'h5000_0000;
        chk("held ar1_addr", 128'(axi_araddr), 128'(32'h4000_0000));
        axi_arready = 1'b1; tick(); axi_arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_beat(32'hD0 + 32'(k), k == 3);
            if (k < 3) chk("held no_second_ar", 128'(axi_arvalid), 128'(1'b0));
        end
        chk("held done",       128'(done),        128'(1'b1));
        chk("held word",       128'(word_data),   128'(32'hD0));
        chk("held arvalid_dn", 128'(axi_arvalid), 128'(1'b0));
        tick();
        chk("held idle_empty",   128'(empty),       128'(1'b1));
        chk("held idle_arvalid", 128'(axi_arvalid), 128'(1'b0));
        tick();
        en = 1'b0;
        chk("held ar2_valid", 128'(axi_arvalid), 128'(1'b1));
        chk("held ar2_addr",  128'(axi_araddr),  128'(32'h5000_0000));
        axi_arready = 1'b1; tick(); axi_arready = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(32'hE0 + 32'(k), k == 3);
        chk("held ar2_line", line_data, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
        tick();

        // Reset after the second beat.
        d0 = done_cnt;
        en = 1'b1; uncached = 1'b0; addr = 32'h6000_0000;
        tick();
        en = 1'b0;
        axi_arready = 1'b1; tick(); axi_arready = 1'b0;
        send_beat(32'hF0, 1'b0);
        send_beat(32'hF1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst arvalid", 128'(axi_arvalid), 128'(1'b0));
        chk("mrst rready",  128'(axi_rready),  128'(1'b0));
        chk("mrst empty",   128'(empty),       128'(1'b1));
        chk("mrst line",    line_data,         128'd0);
        send_beat(32'hF2, 1'b0);
        send_beat(32'hF3, 1'b1);
        tick();
        chk("mrst no_done", 128'(done_cnt - d0), 128'(0));
        chk("mrst line2",   line_data,           128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/read_axi_buffer.md
# read_axi_buffer

AXI4 read-channel initiator for the cache subsystem, the read-side counterpart of the write buffer. Accepts one refill request at a time, either a full cache-line burst or a single uncached beat, issues it on the AR channel, collects R beats into a line register, and presents the line and the requested word to the cache with a one-cycle done pulse. It sits between the I/D cache miss logic and the AXI crossbar read port.

## Interface
Parameters:
- LINE_SIZE, 16, cache line size in bytes; power of two, 8..64; beats per line N = LINE_SIZE/4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  request strobe; sampled only in IDLE
- uncached  in  1  1 = single beat, 0 = line refill
- addr  in  32  request byte address
- size  in  3  AXI size for uncached requests
- empty  out  1  high when in IDLE
- done  out  1  one-cycle pulse, results valid
- line_data  out  LINE_SIZE*8  refilled line, word i at bits [32i+:32]
- word_data  out  32  requested word (uncached: the single beat)
- axi_araddr  out  32
- axi_arlen  out  8
- axi_arsize  out  3
- axi_arburst  out  2
- axi_arvalid  out  1
- axi_arready  in  1
- axi_rdata  in  32
- axi_rlast  in  1
- axi_rvalid  in  1
- axi_rready  out  1

## Operation
- States: IDLE, WAIT_ADDR, WAIT_DATA, DONE.
- IDLE: on en, capture uncached/addr/size, load AR registers, go WAIT_ADDR. en outside IDLE ignored.
- Uncached AR: araddr = addr, arlen = 0, arsize = size, arburst = INCR (2'b01).
- Cached AR: araddr = addr with low log2(LINE_SIZE) bits cleared, arlen = N-1, arsize = 3'd2, arburst = INCR.
- WAIT_ADDR: arvalid held high, AR fields stable until arready; then clear arvalid, beat counter = 0, go WAIT_DATA.
- WAIT_DATA: rready = 1. Each rvalid beat writes rdata into line word index (counter) and increments counter (modulo N, 4-bit with wrap). Uncached: beat goes to word_data. rlast with rvalid ends transfer -> DONE, regardless of counter value.
- DONE: done = 1 for exactly one cycle; cached: word_data = line word addr[log2(LINE_SIZE)-1:2]; go IDLE.
- line_data and word_data hold until next request's first beat is written.

## Timing
- Reset values: axi_arvalid 0, axi_araddr 0, axi_arlen 0, axi_arsize 0, axi_arburst 2'b01, axi_rready 0, done 0, line_data 0, word_data 0, empty 1; state IDLE.
- en at cycle t -> arvalid high at t+1 (all AR outputs registered).
- arready at cycle a (arvalid high) -> rready high from a+1.
- Last beat (rlast) accepted at cycle r -> done high at r+1, empty high at r+2.
- Back-to-back: en may be asserted in the cycle empty is high; min request spacing = 4 cycles with zero-wait slave.
- rvalid in WAIT_ADDR is not accepted (rready 0).
- rst mid-transfer: return to IDLE next cycle, all outputs to reset values; outstanding AXI beats are the interconnect's concern.

## Configuration
- CRITICAL_WORD_FIRST_EN defined: cached AR uses araddr = addr with bits [1:0] cleared, arburst = WRAP (2'b10); beat k stored at word index (start + k) mod N where start = addr[log2(LINE_SIZE)-1:2]; word_data loaded from beat 0 and done unchanged.
- Not defined: INCR, line-aligned address, as in Operation. Uncached path identical in both.

## Structure
- Shared cache package: AXI burst constants (BURST_FIXED/INCR/WRAP), AXI size encodings, state enum for the read buffer, and LINE_SIZE default shared with the write buffer.
- Single module; no sub-module needed (beat index/word select is inline logic).

## Test plan
- Cached refill, LINE_SIZE=16, addr 0x1000_0024, zero-wait slave, beats 0xA0..0xA3 -> araddr 0x1000_0020, arlen 3, arsize 2, arburst 1; done 1 cycle after rlast; line_data = {A3,A2,A1,A0}; word_data = 0xA1.
- Uncached read, addr 0x1FC0_0003, size 0 -> araddr 0x1FC0_0003, arlen 0, arsize 0; single beat 0x55 with rlast -> word_data 0x55, done pulse.
- arready delayed 5 cycles, rvalid gaps between beats -> AR fields stable while arvalid, beats stored in order, done exactly once.
- en held high through a transfer -> second AR only issued after return to IDLE; second request uses addr sampled at that IDLE cycle.
- rst asserted after second beat -> next cycle arvalid 0, rready 0, empty 1, done never pulses.
- CRITICAL_WORD_FIRST_EN, addr 0x1000_0028, beats B0..B3 -> araddr 0x1000_0028, arburst 2; line word2=B0, word3=B1, word0=B2, word1=B3; word_data = B0.
